// File: rtl/machine_mode_types_pkg.sv
`default_nettype none
// ============================================================================
// Module : machine_mode_types_pkg
// Brief  : Machine-mode trap types: sequencer states, cause codes, tval select.
// Rev    : 1.0 - initial release
// ============================================================================
package machine_mode_types_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_HANDOFF  = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    typedef enum logic [1:0] {
        TVAL_ZERO    = 2'd0,
        TVAL_PC      = 2'd1,
        TVAL_BADADDR = 2'd2
    } tval_sel_t;

    typedef logic [4:0] cause_t;

    localparam cause_t C_CAUSE_MAL_INSN         = 5'd0;
    localparam cause_t C_CAUSE_FAULT_INSN       = 5'd1;
    localparam cause_t C_CAUSE_ILLEGAL_INSN     = 5'd2;
    localparam cause_t C_CAUSE_BREAKPOINT       = 5'd3;
    localparam cause_t C_CAUSE_MAL_LOAD         = 5'd4;
    localparam cause_t C_CAUSE_FAULT_LOAD       = 5'd5;
    localparam cause_t C_CAUSE_MAL_STORE        = 5'd6;
    localparam cause_t C_CAUSE_FAULT_STORE      = 5'd7;
    localparam cause_t C_CAUSE_ENV_BASE         = 5'd8;
    localparam cause_t C_CAUSE_FAULT_INSN_PAGE  = 5'd12;
    localparam cause_t C_CAUSE_FAULT_LOAD_PAGE  = 5'd13;
    localparam cause_t C_CAUSE_FAULT_STORE_PAGE = 5'd15;

    // Field order matches the exception input order of the sequencer.
    typedef struct packed {
        logic mal_insn;
        logic fault_insn;
        logic illegal_insn;
        logic breakpoint;
        logic env;
        logic mal_l;
        logic fault_l;
        logic mal_s;
        logic fault_s;
        logic fault_insn_page;
        logic fault_load_page;
        logic fault_store_page;
    } exc_bits_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv32i_types_pkg
// Brief  : Base RV32I datapath types shared across the core.
// Rev    : 1.0 - initial release
// ============================================================================
package rv32i_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/prv_trap_priority_enc.sv
`default_nettype none
// ============================================================================
// Module : prv_trap_priority_enc
// Brief  : Picks the highest-priority synchronous exception and its tval source.
// Rev    : 1.0 - initial release
// ============================================================================
module prv_trap_priority_enc
    import machine_mode_types_pkg::*;
(
    input  exc_bits_t  exc,
    input  logic [1:0] curr_privilege_level,
    output logic       valid,
    output cause_t     cause,
    output tval_sel_t  tval_sel
);

    always_comb begin
        valid    = 1'b1;
        cause    = C_CAUSE_MAL_INSN;
        tval_sel = TVAL_ZERO;
        if (exc.breakpoint) begin
            cause    = C_CAUSE_BREAKPOINT;
            tval_sel = TVAL_PC;
        end else if (exc.fault_insn_page) begin
            cause    = C_CAUSE_FAULT_INSN_PAGE;
            tval_sel = TVAL_PC;
        end else if (exc.fault_insn) begin
            cause    = C_CAUSE_FAULT_INSN;
            tval_sel = TVAL_PC;
        end else if (exc.illegal_insn) begin
            cause    = C_CAUSE_ILLEGAL_INSN;
        end else if (exc.mal_insn) begin
            cause    = C_CAUSE_MAL_INSN;
            tval_sel = TVAL_PC;
        end else if (exc.env) begin
            // ECALL code is offset by the privilege level it was raised from.
            cause    = C_CAUSE_ENV_BASE + {3'b000, curr_privilege_level};
        end else if (exc.mal_l) begin
            cause    = C_CAUSE_MAL_LOAD;
            tval_sel = TVAL_BADADDR;
        end else if (exc.mal_s) begin
            cause    = C_CAUSE_MAL_STORE;
            tval_sel = TVAL_BADADDR;
        end else if (exc.fault_load_page) begin
            cause    = C_CAUSE_FAULT_LOAD_PAGE;
            tval_sel = TVAL_BADADDR;
        end else if (exc.fault_store_page) begin
            cause    = C_CAUSE_FAULT_STORE_PAGE;
            tval_sel = TVAL_BADADDR;
        end else if (exc.fault_l) begin
            cause    = C_CAUSE_FAULT_LOAD;
            tval_sel = TVAL_BADADDR;
        end else if (exc.fault_s) begin
            cause    = C_CAUSE_FAULT_STORE;
            tval_sel = TVAL_BADADDR;
        end else begin
            valid    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prv_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module : prv_trap_sequencer
// Brief  : Latches a trap at commit, flushes, hands off to priv block, redirects.
// Rev    : 1.0 - initial release
// ============================================================================
module prv_trap_sequencer
    import machine_mode_types_pkg::*;
    import rv32i_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  word_t       ex_pc,
    input  word_t       ex_badaddr,
    input  logic        mal_insn,
    input  logic        fault_insn,
    input  logic        illegal_insn,
    input  logic        breakpoint,
    input  logic        env,
    input  logic        mal_l,
    input  logic        fault_l,
    input  logic        mal_s,
    input  logic        fault_s,
    input  logic        fault_insn_page,
    input  logic        fault_load_page,
    input  logic        fault_store_page,
    input  logic [1:0]  curr_privilege_level,
    input  logic        intr,
    input  logic [3:0]  intr_cause,
    input  logic        insert_pc,
    input  word_t       priv_pc,
    output logic        pipe_clear,
    output logic        trap_req,
    output logic        trap_is_intr,
    output logic [4:0]  trap_cause,
    output word_t       trap_epc,
    output word_t       trap_tval,
    output logic        redirect_valid,
    output word_t       redirect_pc,
    output logic        busy
);

    trap_state_t r_state;
    trap_state_t w_state_next;
    exc_bits_t   w_exc;
    logic        w_enc_valid;
    cause_t      w_enc_cause;
    tval_sel_t   w_enc_tval_sel;
    logic        w_latch;
    logic        w_capture_redirect;
    logic        r_is_intr;
    cause_t      r_cause;
    word_t       r_epc;
    word_t       r_tval;
    word_t       r_redirect_pc;

    assign w_exc = {mal_insn, fault_insn, illegal_insn, breakpoint, env,
                    mal_l, fault_l, mal_s, fault_s,
                    fault_insn_page, fault_load_page, fault_store_page};

    prv_trap_priority_enc u_priority_enc (
        .exc                  (w_exc),
        .curr_privilege_level (curr_privilege_level),
        .valid                (w_enc_valid),
        .cause                (w_enc_cause),
        .tval_sel             (w_enc_tval_sel)
    );

    function automatic word_t sel_tval(tval_sel_t sel, word_t pc, word_t badaddr);
        case (sel)
            TVAL_PC:      sel_tval = pc;
            TVAL_BADADDR: sel_tval = badaddr;
            default:      sel_tval = '0;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_latch            = 1'b0;
        w_capture_redirect = 1'b0;
        pipe_clear         = 1'b0;
        trap_req           = 1'b0;
        redirect_valid     = 1'b0;
        busy               = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (ex_valid && !ex_stall && (intr || w_enc_valid)) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                pipe_clear   = 1'b1;
                w_state_next = ST_HANDOFF;
            end
            ST_HANDOFF: begin
                trap_req = 1'b1;
                if (insert_pc) begin
                    w_capture_redirect = 1'b1;
                    w_state_next       = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                w_state_next   = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Interrupts take precedence over any exception committing alongside them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_is_intr     <= 1'b0;
            r_cause       <= '0;
            r_epc         <= '0;
            r_tval        <= '0;
            r_redirect_pc <= '0;
        end else begin
            if (w_latch) begin
                r_is_intr <= intr;
                r_cause   <= intr ? {1'b0, intr_cause} : w_enc_cause;
                r_epc     <= ex_pc;
                r_tval    <= intr ? '0 : sel_tval(w_enc_tval_sel, ex_pc, ex_badaddr);
            end
            if (w_capture_redirect) begin
                r_redirect_pc <= priv_pc;
            end
        end
    end

    assign trap_is_intr = r_is_intr;
    assign trap_cause   = r_cause;
    assign trap_epc     = r_epc;
    assign trap_tval    = r_tval;
    assign redirect_pc  = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_prv_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_prv_trap_sequencer
// Brief  : Directed scoreboard bench for the trap sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_prv_trap_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_stall = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_badaddr = '0;
    logic        mal_insn = 1'b0, fault_insn = 1'b0, illegal_insn = 1'b0, breakpoint = 1'b0;
    logic        env = 1'b0, mal_l = 1'b0, fault_l = 1'b0, mal_s = 1'b0, fault_s = 1'b0;
    logic        fault_insn_page = 1'b0, fault_load_page = 1'b0, fault_store_page = 1'b0;
    logic [1:0]  curr_privilege_level = 2'd3;
    logic        intr = 1'b0;
    logic [3:0]  intr_cause = '0;
    logic        insert_pc = 1'b0;
    logic [31:0] priv_pc = '0;
    logic        pipe_clear, trap_req, trap_is_intr, redirect_valid, busy;
    logic [4:0]  trap_cause;
    logic [31:0] trap_epc, trap_tval, redirect_pc;

    localparam logic [11:0] E_MAL_INSN = 12'h800, E_FAULT_INSN = 12'h400, E_ILLEGAL = 12'h200;
    localparam logic [11:0] E_BRK = 12'h100, E_ENV = 12'h080, E_MAL_L = 12'h040;
    localparam logic [11:0] E_FAULT_L = 12'h020, E_MAL_S = 12'h010, E_FAULT_S = 12'h008;
    localparam logic [11:0] E_FI_PAGE = 12'h004, E_FL_PAGE = 12'h002, E_FS_PAGE = 12'h001;

    typedef struct packed {
        logic        is_intr;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;

    prv_trap_sequencer dut (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_pc(ex_pc), .ex_badaddr(ex_badaddr),
        .mal_insn(mal_insn), .fault_insn(fault_insn), .illegal_insn(illegal_insn),
        .breakpoint(breakpoint), .env(env), .mal_l(mal_l), .fault_l(fault_l),
        .mal_s(mal_s), .fault_s(fault_s), .fault_insn_page(fault_insn_page),
        .fault_load_page(fault_load_page), .fault_store_page(fault_store_page),
        .curr_privilege_level(curr_privilege_level), .intr(intr), .intr_cause(intr_cause),
        .insert_pc(insert_pc), .priv_pc(priv_pc),
        .pipe_clear(pipe_clear), .trap_req(trap_req), .trap_is_intr(trap_is_intr),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_exc(input logic [11:0] v);
        {mal_insn, fault_insn, illegal_insn, breakpoint, env, mal_l, fault_l,
         mal_s, fault_s, fault_insn_page, fault_load_page, fault_store_page} = v;
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_is_intr"}, {31'd0, trap_is_intr}, {31'd0, cur.is_intr});
        chk({tag, "_cause"},   {27'd0, trap_cause},   {27'd0, cur.cause});
        chk({tag, "_epc"},     trap_epc,              cur.epc);
        chk({tag, "_tval"},    trap_tval,             cur.tval);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outputs"},
            {26'd0, pipe_clear, trap_req, trap_is_intr, redirect_valid, busy, 1'b0},
            32'd0);
        chk({tag, "_cause"}, {27'd0, trap_cause}, 32'd0);
        chk({tag, "_epc"}, trap_epc, 32'd0);
        chk({tag, "_tval"}, trap_tval, 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    endtask

    // Commit at cycle N, expect pipe_clear at N+1 and trap_req at N+2.
    task automatic commit_trap(input logic [31:0] pc, input logic [31:0] badaddr,
                               input logic [11:0] exc, input logic in_intr,
                               input logic [3:0] icause, input logic [1:0] priv,
                               input logic x_intr, input logic [4:0] x_cause,
                               input logic [31:0] x_tval, input logic early_insert);
        exp_t e;
        @(posedge CLK); #1;
        ex_valid = 1'b1; ex_pc = pc; ex_badaddr = badaddr; set_exc(exc);
        intr = in_intr; intr_cause = icause; curr_privilege_level = priv;
        e.is_intr = x_intr; e.cause = x_cause; e.epc = pc; e.tval = x_tval;
        sb.push_back(e);
        @(posedge CLK); #1;
        ex_valid = 1'b0; set_exc(12'h000); intr = 1'b0; insert_pc = early_insert;
        @(negedge CLK);
        chk("flush_pipe_clear", {31'd0, pipe_clear}, 32'd1);
        chk("flush_trap_req", {31'd0, trap_req}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd1);
        @(posedge CLK); #1;
        insert_pc = 1'b0;
        @(negedge CLK);
        chk("handoff_trap_req", {31'd0, trap_req}, 32'd1);
        chk("handoff_pipe_clear", {31'd0, pipe_clear}, 32'd0);
        chk("handoff_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=0 expected=1 entry");
        end else begin
            cur = sb.pop_front();
            check_fields("trap");
        end
    endtask

    task automatic finish_handoff(input int hold, input logic [31:0] ppc, input logic poke);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            if (poke && i == 1) begin
                ex_valid = 1'b1; ex_pc = 32'hDEAD_0000; ex_badaddr = 32'hBEEF_0000;
                set_exc(E_ILLEGAL | E_BRK); intr = 1'b1; intr_cause = 4'h3;
            end else begin
                ex_valid = 1'b0; set_exc(12'h000); intr = 1'b0;
            end
            @(negedge CLK);
            chk("hold_trap_req", {31'd0, trap_req}, 32'd1);
            check_fields("hold");
        end
        @(posedge CLK); #1;
        ex_valid = 1'b0; set_exc(12'h000); intr = 1'b0;
        insert_pc = 1'b1; priv_pc = ppc;
        @(negedge CLK);
        chk("accept_trap_req", {31'd0, trap_req}, 32'd1);
        @(posedge CLK); #1;
        insert_pc = 1'b0; priv_pc = 32'h0;
        @(negedge CLK);
        chk("redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("redirect_pc", redirect_pc, ppc);
        chk("redirect_trap_req", {31'd0, trap_req}, 32'd0);
        chk("redirect_busy", {31'd0, busy}, 32'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("post_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("post_redirect_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Commit with nothing to report is dropped.
        @(posedge CLK); #1; ex_valid = 1'b1; ex_pc = 32'h50;
        @(posedge CLK); #1; ex_valid = 1'b0;
        @(negedge CLK);
        chk("plain_commit_busy", {31'd0, busy}, 32'd0);

        // Stalled commit never latches.
        @(posedge CLK); #1; ex_valid = 1'b1; ex_stall = 1'b1; set_exc(E_ILLEGAL);
        @(posedge CLK); #1; ex_valid = 1'b0; ex_stall = 1'b0; set_exc(12'h000);
        @(negedge CLK);
        chk("stalled_busy", {31'd0, busy}, 32'd0);

        // Stray insert_pc while idle.
        @(posedge CLK); #1; insert_pc = 1'b1; priv_pc = 32'h1234;
        @(posedge CLK); #1; insert_pc = 1'b0;
        @(negedge CLK);
        chk("idle_insert_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("idle_insert_busy", {31'd0, busy}, 32'd0);

        commit_trap(32'h100, 32'hABCD, E_ILLEGAL, 0, 0, 2'd3, 0, 5'd2, 32'h0, 0);
        finish_handoff(1, 32'h8000_0000, 0);
        commit_trap(32'h200, 32'h2003, E_MAL_L | E_FL_PAGE, 0, 0, 2'd3, 0, 5'd4, 32'h2003, 1);
        finish_handoff(5, 32'h8000_0004, 1);
        commit_trap(32'h300, 32'h5555, E_FAULT_S, 1, 4'd7, 2'd3, 1, 5'd7, 32'h0, 0);
        finish_handoff(1, 32'h8000_0008, 0);
        commit_trap(32'h310, 32'h0, E_ENV, 0, 0, 2'd0, 0, 5'd8, 32'h0, 0);
        finish_handoff(0, 32'h8000_000C, 0);
        commit_trap(32'h320, 32'h0, E_ENV, 0, 0, 2'd3, 0, 5'd11, 32'h0, 0);
        finish_handoff(0, 32'h8000_0010, 0);
        commit_trap(32'h400, 32'h44, E_BRK | E_FI_PAGE | E_ILLEGAL, 0, 0, 2'd3, 0, 5'd3, 32'h400, 0);
        finish_handoff(0, 32'h8000_0014, 0);
        commit_trap(32'h410, 32'h44, E_FI_PAGE | E_FAULT_INSN, 0, 0, 2'd3, 0, 5'd12, 32'h410, 0);
        finish_handoff(0, 32'h8000_0018, 0);
        commit_trap(32'h420, 32'h44, E_FAULT_INSN | E_ILLEGAL, 0, 0, 2'd3, 0, 5'd1, 32'h420, 0);
        finish_handoff(0, 32'h8000_001C, 0);
        commit_trap(32'h430, 32'h44, E_MAL_INSN | E_ENV, 0, 0, 2'd3, 0, 5'd0, 32'h430, 0);
        finish_handoff(0, 32'h8000_0020, 0);
        commit_trap(32'h440, 32'h48, E_ENV | E_MAL_L, 0, 0, 2'd1, 0, 5'd9, 32'h0, 0);
        finish_handoff(0, 32'h8000_0024, 0);
        commit_trap(32'h450, 32'h4C, E_MAL_S | E_FL_PAGE, 0, 0, 2'd3, 0, 5'd6, 32'h4C, 0);
        finish_handoff(0, 32'h8000_0028, 0);
        commit_trap(32'h460, 32'h50, E_FL_PAGE | E_FS_PAGE, 0, 0, 2'd3, 0, 5'd13, 32'h50, 0);
        finish_handoff(0, 32'h8000_002C, 0);
        commit_trap(32'h470, 32'h54, E_FS_PAGE | E_FAULT_L, 0, 0, 2'd3, 0, 5'd15, 32'h54, 0);
        finish_handoff(0, 32'h8000_0030, 0);
        commit_trap(32'h480, 32'h58, E_FAULT_L | E_FAULT_S, 0, 0, 2'd3, 0, 5'd5, 32'h58, 0);
        finish_handoff(0, 32'h8000_0034, 0);
        commit_trap(32'h490, 32'h5C, E_FAULT_S, 0, 0, 2'd3, 0, 5'd7, 32'h5C, 0);
        finish_handoff(0, 32'h8000_0038, 0);

        // Asynchronous reset mid-handoff, away from any clock edge.
        commit_trap(32'h900, 32'h60, E_ILLEGAL, 0, 0, 2'd3, 0, 5'd2, 32'h0, 0);
        #2 nRST = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge CLK); #1;
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("post_reset_trap_req", {31'd0, trap_req}, 32'd0);
            chk("post_reset_busy", {31'd0, busy}, 32'd0);
        end

        commit_trap(32'hA00, 32'h64, E_MAL_L, 0, 0, 2'd3, 0, 5'd4, 32'h64, 0);
        finish_handoff(0, 32'h8000_0040, 0);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
